// File: rtl/dma_pkg.sv
// Shared constants and state encoding for the bus DMA engine.
package dma_pkg;

  localparam int          DMA_ADDR_STEP = 4;
  localparam logic [31:0] DMA_IO_BASE   = 32'hF000_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } dma_state_e;

  typedef struct packed {
    logic cmd_ready;
    logic busy;
    logic bus_req;
    logic done;
  } dma_flags_t;

  // Status outputs are a pure function of the state being entered, so they
  // can be registered alongside the state itself.
  function automatic dma_flags_t state_flags(input dma_state_e s);
    dma_flags_t f;
    f.cmd_ready = (s == ST_IDLE);
    f.busy      = (s != ST_IDLE);
    f.bus_req   = (s == ST_ARB) || (s == ST_RD) || (s == ST_WR);
    f.done      = (s == ST_FIN);
    return f;
  endfunction

endpackage

// File: rtl/dma_ptr.sv
// Loadable byte-address register that advances by a fixed step per word.
module dma_ptr
  import dma_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int STEP  = DMA_ADDR_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DBITS-1:0] i_load_val,
  input  logic             i_inc,
  output logic [DBITS-1:0] o_addr
);

  localparam logic [DBITS-1:0] STEP_W = DBITS'(STEP);

  logic [DBITS-1:0] r_addr;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_inc) begin
      r_addr <= r_addr + STEP_W;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/bus_dma.sv
// Single-channel memory-to-memory copy engine: arbitrates for the shared bus,
// then alternates read and write cycles word by word.
module bus_dma
  import dma_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int CNT_BITS  = 16,
  parameter int ADDR_STEP = DMA_ADDR_STEP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DBITS-1:0]    src_addr,
  input  logic [DBITS-1:0]    dst_addr,
  input  logic [CNT_BITS-1:0] word_count,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic [DBITS-1:0]    abus,
  output logic [DBITS-1:0]    dbus_out,
  output logic                dbus_oe,
  input  logic [DBITS-1:0]    dbus_in,
  output logic                we,
  output logic                busy,
  output logic                done
);

  dma_state_e          r_state;
  dma_flags_t          r_flags;
  logic [CNT_BITS-1:0] r_count;
  logic [DBITS-1:0]    r_hold;

  logic [DBITS-1:0]    w_src;
  logic [DBITS-1:0]    w_dst;
  logic                w_accept;
  logic                w_rd_act;
  logic                w_wr_act;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_rd_act = (r_state == ST_RD) && bus_gnt;
  assign w_wr_act = (r_state == ST_WR) && bus_gnt;

  // Both pointers step only on a granted write, so a stall never skips a word.
  dma_ptr #(.DBITS(DBITS), .STEP(ADDR_STEP)) u_src_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (src_addr),
    .i_inc      (w_wr_act),
    .o_addr     (w_src)
  );

  dma_ptr #(.DBITS(DBITS), .STEP(ADDR_STEP)) u_dst_ptr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (dst_addr),
    .i_inc      (w_wr_act),
    .o_addr     (w_dst)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_flags <= state_flags(ST_IDLE);
      r_count <= '0;
      // NOTE: the data holding register is cleared too, so no stale word from
      // an abandoned transfer survives reset.
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_count <= word_count;
            if (word_count == '0) begin
              r_state <= ST_FIN;
              r_flags <= state_flags(ST_FIN);
            end else begin
              r_state <= ST_ARB;
              r_flags <= state_flags(ST_ARB);
            end
          end
        end
        ST_ARB: begin
          if (bus_gnt) begin
            r_state <= ST_RD;
            r_flags <= state_flags(ST_RD);
          end
        end
        ST_RD: begin
          if (bus_gnt) begin
            r_hold  <= dbus_in;
            r_state <= ST_WR;
            r_flags <= state_flags(ST_WR);
          end
        end
        ST_WR: begin
          if (bus_gnt) begin
            r_count <= r_count - CNT_BITS'(1);
            if (r_count == CNT_BITS'(1)) begin
              r_state <= ST_FIN;
              r_flags <= state_flags(ST_FIN);
            end else begin
              r_state <= ST_RD;
              r_flags <= state_flags(ST_RD);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_flags <= state_flags(ST_IDLE);
        end
      endcase
    end
  end

  assign cmd_ready = r_flags.cmd_ready;
  assign busy      = r_flags.busy;
  assign bus_req   = r_flags.bus_req;
  assign done      = r_flags.done;

  // Bus drive follows the grant combinationally so the CPU can take the bus
  // back in the same cycle it withdraws the grant.
  assign abus     = w_rd_act ? w_src : (w_wr_act ? w_dst : '0);
  assign dbus_out = w_wr_act ? r_hold : '0;
  assign dbus_oe  = w_wr_act;
  assign we       = w_wr_act;

endmodule

// File: tb/tb_bus_dma.sv
// Scoreboard bench for bus_dma: a memory/LEDR model answers bus cycles and a
// monitor pops expected reads/writes as the DUT issues them.
module tb_bus_dma;
  import dma_pkg::*;

  localparam logic [31:0] LEDR_ADDR = DMA_IO_BASE + 32'd4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [31:0] abus;
  logic [31:0] dbus_out;
  logic        dbus_oe;
  logic [31:0] dbus_in;
  logic        we;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:255];
  logic [31:0] ledr = '0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  wr_t         mon_e;
  logic [31:0] mon_ra;
  logic [31:0] last_rd = '0;

  int n_checks = 0;
  int n_fail   = 0;

  bus_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .abus       (abus),
    .dbus_out   (dbus_out),
    .dbus_oe    (dbus_oe),
    .dbus_in    (dbus_in),
    .we         (we),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Memory responder: combinational read, write captured on the clock edge.
  assign dbus_in = mem[abus[9:2]];

  always @(posedge clk) begin
    if (we) begin
      if (abus == LEDR_ADDR) ledr <= dbus_out;
      else                   mem[abus[9:2]] <= dbus_out;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end
  end

  // Scoreboard monitor: the last granted non-write cycle before a write is its read.
  always @(negedge clk) begin
    #4;
    if (bus_req && bus_gnt && !we) last_rd = abus;
    if (we) begin
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, want no write", abus, dbus_out);
      end else begin
        mon_e = exp_wr.pop_front();
        if (abus !== mon_e.addr || dbus_out !== mon_e.data || dbus_oe !== 1'b1) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h oe=%b, want addr=%h data=%h oe=1",
                   abus, dbus_out, dbus_oe, mon_e.addr, mon_e.data);
        end
      end
      n_checks++;
      if (exp_rd.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got read addr=%h, want none", last_rd);
      end else begin
        mon_ra = exp_rd.pop_front();
        if (last_rd !== mon_ra) begin
          n_fail++;
          $display("FAIL read_addr: got %h want %h", last_rd, mon_ra);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    pl_idx  = idx;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] d);
    exp_rd.push_back(ra);
    exp_wr.push_back('{addr: wa, data: d});
  endtask

  // Issues one command and steps until done (bounded); k counts clock cycles from accept.
  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int drop_at, input int drop_len, input bit junk,
                         output int lat, output bit saw_req, output bit stall_bad,
                         output bit pulse_bad);
    lat = 0; saw_req = 1'b0; stall_bad = 1'b0; pulse_bad = 1'b0;
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = n; cmd_valid = 1'b1;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (junk) begin
        src_addr = 32'h3C0; dst_addr = 32'h3E0; word_count = 16'd7;
      end else begin
        cmd_valid = 1'b0;
      end
      bus_gnt = !(k >= drop_at && k < drop_at + drop_len);
      #2;
      if (bus_req) saw_req = 1'b1;
      if (!bus_gnt && (we || dbus_oe || abus != '0 || !bus_req)) stall_bad = 1'b1;
      if (done) lat = k;
    end
    cmd_valid = 1'b0;
    bus_gnt   = 1'b1;
    @(negedge clk);
    #2;
    if (done || !cmd_ready || busy) pulse_bad = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    n_checks++;
    if ({cmd_ready, bus_req, dbus_oe, we, busy, done} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/req/oe/we/busy/done=%b want 100000",
               {cmd_ready, bus_req, dbus_oe, we, busy, done});
    end
    n_checks++;
    if (abus !== '0) begin n_fail++; $display("FAIL reset_abus: got %h want 0", abus); end
    n_checks++;
    if (dbus_out !== '0) begin n_fail++; $display("FAIL reset_dbus_out: got %h want 0", dbus_out); end
    reset = 1'b0;
  endtask

  task automatic test_copy();
    int lat; bit req; bit stall; bit pulse;
    preload(8'd64, 32'h11); preload(8'd65, 32'h22); preload(8'd66, 32'h33);
    expect_word(32'h100, 32'h200, 32'h11);
    expect_word(32'h104, 32'h204, 32'h22);
    expect_word(32'h108, 32'h208, 32'h33);
    run_cmd(32'h100, 32'h200, 16'd3, 0, 0, 1'b0, lat, req, stall, pulse);
    n_checks++;
    if (lat != 8) begin n_fail++; $display("FAIL copy_latency: got %0d want 8", lat); end
    n_checks++;
    if (pulse) begin n_fail++; $display("FAIL copy_done_pulse: got done stuck or not idle, want 1-cycle pulse"); end
    n_checks++;
    if (exp_wr.size() != 0) begin n_fail++; $display("FAIL copy_writes_left: got %0d pending want 0", exp_wr.size()); end
  endtask

  task automatic test_zero_len();
    int lat; bit req; bit stall; bit pulse;
    run_cmd(32'h100, 32'h200, 16'd0, 0, 0, 1'b0, lat, req, stall, pulse);
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL zero_latency: got %0d want 1", lat); end
    n_checks++;
    if (req) begin n_fail++; $display("FAIL zero_bus_req: got bus_req seen=1 want 0"); end
    n_checks++;
    if (pulse) begin n_fail++; $display("FAIL zero_done_pulse: got done stuck or not idle, want 1-cycle pulse"); end
  endtask

  task automatic test_grant_loss();
    int lat; bit req; bit stall; bit pulse;
    preload(8'd192, 32'hA1); preload(8'd193, 32'hA2); preload(8'd194, 32'hA3);
    expect_word(32'h300, 32'h380, 32'hA1);
    expect_word(32'h304, 32'h384, 32'hA2);
    expect_word(32'h308, 32'h388, 32'hA3);
    // Cycle 5 after accept is the WR of word 2; withhold the grant for 3 cycles there.
    run_cmd(32'h300, 32'h380, 16'd3, 5, 3, 1'b0, lat, req, stall, pulse);
    n_checks++;
    if (stall) begin n_fail++; $display("FAIL stall_outputs: got bus drive or bus_req drop during stall, want quiet bus"); end
    n_checks++;
    if (lat != 11) begin n_fail++; $display("FAIL stall_latency: got %0d want 11", lat); end
    n_checks++;
    if (exp_wr.size() != 0) begin n_fail++; $display("FAIL stall_writes_left: got %0d pending want 0", exp_wr.size()); end
  endtask

  task automatic test_wrap();
    int lat; bit req; bit stall; bit pulse;
    preload(8'd255, 32'hCAFE_0001); preload(8'd0, 32'hCAFE_0002);
    expect_word(32'hFFFF_FFFC, 32'h40, 32'hCAFE_0001);
    expect_word(32'h0000_0000, 32'h44, 32'hCAFE_0002);
    run_cmd(32'hFFFF_FFFC, 32'h40, 16'd2, 0, 0, 1'b0, lat, req, stall, pulse);
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL wrap_latency: got %0d want 6", lat); end
    n_checks++;
    if (exp_rd.size() != 0) begin n_fail++; $display("FAIL wrap_reads_left: got %0d pending want 0", exp_rd.size()); end
  endtask

  task automatic test_device();
    int lat; bit req; bit stall; bit pulse;
    preload(8'd4, 32'h3FF);
    expect_word(32'h10, LEDR_ADDR, 32'h3FF);
    run_cmd(32'h10, LEDR_ADDR, 16'd1, 0, 0, 1'b0, lat, req, stall, pulse);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL device_latency: got %0d want 4", lat); end
    n_checks++;
    if (ledr !== 32'h3FF) begin n_fail++; $display("FAIL device_ledr: got %h want 000003ff", ledr); end
  endtask

  task automatic test_ignore_cmd();
    int lat; bit req; bit stall; bit pulse;
    // cmd_valid stays high with different operands for the whole transfer.
    expect_word(32'h100, 32'h240, 32'h11);
    expect_word(32'h104, 32'h244, 32'h22);
    run_cmd(32'h100, 32'h240, 16'd2, 0, 0, 1'b1, lat, req, stall, pulse);
    n_checks++;
    if (lat != 6) begin n_fail++; $display("FAIL ignore_latency: got %0d want 6", lat); end
    n_checks++;
    if (pulse) begin n_fail++; $display("FAIL ignore_accepted: got busy after done, want idle"); end
    n_checks++;
    if (exp_wr.size() != 0) begin n_fail++; $display("FAIL ignore_writes_left: got %0d pending want 0", exp_wr.size()); end
  endtask

  task automatic test_reset_mid();
    int lat; bit req; bit stall; bit pulse; bit quiet_bad;
    for (int i = 0; i < 4; i++) preload(8'(8 + i), 32'hB1 + 32'(i));
    for (int i = 0; i < 4; i++) preload(8'(24 + i), 32'hDEAD_0000 + 32'(i));
    expect_word(32'h20, 32'h60, 32'hB1);
    @(negedge clk);
    src_addr = 32'h20; dst_addr = 32'h60; word_count = 16'd4; cmd_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    #2;
    n_checks++;
    if ({cmd_ready, bus_req, dbus_oe, we, busy, done} !== 6'b100000 || abus !== '0 || dbus_out !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got flags=%b abus=%h dout=%h want 100000/0/0",
               {cmd_ready, bus_req, dbus_oe, we, busy, done}, abus, dbus_out);
    end
    reset = 1'b0;
    quiet_bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      #2;
      if (done || we || bus_req) quiet_bad = 1'b1;
    end
    n_checks++;
    if (quiet_bad) begin n_fail++; $display("FAIL midreset_quiet: got done/we/bus_req after reset want none"); end
    n_checks++;
    if (mem[25] !== 32'hDEAD_0001) begin n_fail++; $display("FAIL midreset_word2: got %h want dead0001", mem[25]); end
    n_checks++;
    if (exp_wr.size() != 0) begin n_fail++; $display("FAIL midreset_word1: got %0d pending want 0", exp_wr.size()); end
    expect_word(32'h20, 32'h70, 32'hB1);
    run_cmd(32'h20, 32'h70, 16'd1, 0, 0, 1'b0, lat, req, stall, pulse);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL midreset_recover: got latency %0d want 4", lat); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_zero_len();
    test_grant_loss();
    test_wrap();
    test_device();
    test_ignore_cmd();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
